darkdmem: RTL and testbench
===========================

# darkdmem

Data-side memory and simulation-I/O responder for the darkriscv core. Sits directly downstream of the core's data bus (DADDR/DATAO/DLEN/DRD/DWR/DAS) and produces DATAI and the HLT stall. Provides a word-organised on-chip RAM with byte-lane writes, programmable read wait states, and a small memory-mapped I/O page. The I/O page holds a console TX port and a finish/exit register, used by the simulation bench to end a run.

## Interface
- MLEN, 12: RAM word-address width; RAM holds 2^MLEN 32-bit words.
- WAITS, 1: extra read wait states, 0..15.
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock; all state updates on rising edge.
- RES  in  1  synchronous active-high reset.
- DAS  in  1  data address strobe; marks a valid access.
- DRD  in  1  read request, qualified by DAS.
- DWR  in  1  write request, qualified by DAS.
- DADDR  in  32  byte address.
- DATAO  in  32  write data; lanes already positioned by the core.
- DLEN  in  3  access size: 3'b001 byte, 3'b010 half, 3'b100 word.
- DATAI  out  32  read data; full aligned word.
- HLT  out  1  stall to the core.
- CON_VALID  out  1  console byte available.
- CON_DATA  out  8  console byte.
- CON_READY  in  1  bench accepts the console byte.
- FINISH  out  1  finish register written; sticky.
- EXIT  out  32  value written to the finish register.
- ERR  out  1  sticky protocol or alignment error.

## Operation
- A request is DAS=1 with DRD or DWR set. DRD and DWR both set: executed as a read, ERR set.
- Address decode:
  - DADDR[31]=0 selects RAM at word index DADDR[MLEN+1:2]. Upper bits are ignored, so addresses wrap.
  - DADDR[31]=1 selects I/O, decoded on DADDR[3:2]:
    - 0: console TX, write only.
    - 1: status, read; bit0 = CON_VALID.
    - 2: finish/exit, write.
    - 3: reserved; reads return 0, writes are ignored.
- Byte enables:
  - Byte access: lane DADDR[1:0].
  - Half access: lanes 1:0 when DADDR[1]=0, lanes 3:2 when DADDR[1]=1.
  - Word access: all lanes.
  - Misaligned access (half with DADDR[0]=1, word with DADDR[1:0]≠0): no write, ERR set, still acknowledged.
  - Invalid DLEN (not one-hot): ERR set, no write.
- FSM states are IDLE, WAIT, ACK.
  - IDLE with a read request: HLT=1, load counter with WAITS. Go to ACK if WAITS=0, else to WAIT.
  - WAIT: HLT=1, decrement the counter. Go to ACK when the counter reaches 1.
  - ACK: DATAI is driven with the registered read word, HLT=0 for exactly 1 cycle, then back to IDLE.
- Writes in IDLE complete in the same cycle with HLT=0 and no state change. Exception: a console write while CON_VALID=1 holds HLT=1 until CON_READY has drained the pending byte.
- Console write: CON_DATA is loaded with DATAO[7:0] and CON_VALID is set. CON_VALID clears on the cycle CON_VALID & CON_READY. A write in the same cycle as the drain is stalled one cycle and then accepted.
- Finish write: EXIT is loaded with DATAO and FINISH set to 1. Later finish writes update EXIT.

## Timing
- Reset values: state IDLE, HLT=0, DATAI=0, CON_VALID=0, CON_DATA=0, FINISH=0, EXIT=0, ERR=0, counter=0. RAM contents are not reset.
- HLT is combinational from DAS/DRD/DWR and state. It is forced to 0 while RES=1.
- Read latency: HLT is high for WAITS+1 cycles starting at the request cycle. Data is valid on DATAI in the following ACK cycle, with HLT=0.
- The core holds DADDR/DLEN/DRD stable while HLT=1. The address is registered on entry from IDLE; later changes are ignored until ACK.
- DATAI holds its last value outside ACK.
- Reset asserted in WAIT or ACK: the FSM returns to IDLE on that edge, the pending read is dropped, and HLT=0 on the next cycle.
- Write-to-read of the same address on consecutive requests returns the new data.

## Test plan
- WAITS=2; word write 0xDEADBEEF to 0x10, then word read 0x10 → write shows no HLT. Read shows HLT high 3 cycles, then DATAI=0xDEADBEEF with HLT=0 for 1 cycle.
- Byte write 0xAA to 0x13 over a word of 0x11223344 → read of 0x10 returns 0xAA223344. Half write 0x5566 (lanes 1:0) to 0x10 → read returns 0xAA225566.
- Word write to 0x12 → ERR=1, RAM unchanged, HLT=0.
- Console: write 'A' (0x41) to 0x80000000 with CON_READY=0, then write 'B' → second write stalls with HLT=1. Raise CON_READY → CON_DATA=0x41 is taken, then 0x42 is accepted with HLT dropped.
- Write 0x2A to 0x80000008 → FINISH=1, EXIT=0x0000002A, sticky until RES.
- Assert RES during WAIT (WAITS=4) → next cycle HLT=0, state IDLE. A fresh read completes normally with 5 stall cycles.

Source files
------------

// File: rtl/darkdmem_if.sv
// darkdmem_if: data-side bus between the darkriscv core and darkdmem.
//
// Handshake: a request is offered when DAS=1 with DRD or DWR set. HLT acts as
// the inverse of ready. A request completes on the first rising edge where
// HLT=0, and the core holds DADDR/DATAO/DLEN/DRD/DWR stable while HLT=1. Read
// data is valid on DATAI in the cycle where a read request sees HLT=0.
interface darkdmem_if;
   logic        DAS;
   logic        DRD;
   logic        DWR;
   logic [31:0] DADDR;
   logic [31:0] DATAO;
   logic [2:0]  DLEN;
   logic [31:0] DATAI;
   logic        HLT;

   modport master (output DAS, DRD, DWR, DADDR, DATAO, DLEN, input DATAI, HLT);
   modport slave  (input DAS, DRD, DWR, DADDR, DATAO, DLEN, output DATAI, HLT);
endinterface

// File: rtl/darkdmem.sv
// darkdmem: data memory and simulation I/O page for the darkriscv core.
// Word-organised RAM with byte-lane writes and WAITS read wait states. The I/O
// page (DADDR[31]=1) holds a console TX port, a status word and a finish/exit
// register.
module darkdmem #(
   parameter int MLEN  = 12,
   parameter int WAITS = 1
) (
   input  logic        CLK,
   input  logic        RES,
   darkdmem_if.slave   bus,
   output logic        CON_VALID,
   output logic [7:0]  CON_DATA,
   input  logic        CON_READY,
   output logic        FINISH,
   output logic [31:0] EXIT,
   output logic        ERR,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [3:0] WAITS_L = 4'(WAITS);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] datai_q;
   logic [31:0] ram [2**MLEN];

   logic        req_rd;
   logic        req_wr;
   logic        len_ok;
   logic        misalign;
   logic        bad_acc;
   logic        acc_err;
   logic        wr_ok;
   logic        io_sel;
   logic        ram_we;
   logic        con_we;
   logic        con_stall;
   logic        fin_we;
   logic [3:0]  lanes;
   logic [31:0] rd_addr;
   logic [31:0] rd_word;
   logic        unused_addr;

   // Request decode: access type, byte lanes, alignment and target select.
   always_comb begin
      req_rd   = bus.DAS & bus.DRD;
      // a request with both DRD and DWR is treated as a read
      req_wr   = bus.DAS & bus.DWR & ~bus.DRD;
      len_ok   = (bus.DLEN == 3'b001) || (bus.DLEN == 3'b010) || (bus.DLEN == 3'b100);
      misalign = ((bus.DLEN == 3'b010) && bus.DADDR[0]) ||
                 ((bus.DLEN == 3'b100) && (bus.DADDR[1:0] != 2'b00));
      bad_acc  = ~len_ok | misalign;
      acc_err  = ~RES && (state == IDLE) && bus.DAS && (bus.DRD || bus.DWR) &&
                 (bad_acc || (bus.DRD && bus.DWR));
      case (bus.DLEN)
         3'b001:  lanes = 4'b0001 << bus.DADDR[1:0];
         3'b010:  lanes = bus.DADDR[1] ? 4'b1100 : 4'b0011;
         3'b100:  lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
      io_sel    = bus.DADDR[31];
      wr_ok     = ~RES && (state == IDLE) && req_wr && ~bad_acc;
      ram_we    = wr_ok && ~io_sel;
      con_we    = wr_ok && io_sel && (bus.DADDR[3:2] == 2'd0) && ~CON_VALID;
      con_stall = wr_ok && io_sel && (bus.DADDR[3:2] == 2'd0) && CON_VALID;
      fin_we    = wr_ok && io_sel && (bus.DADDR[3:2] == 2'd2);
   end

   // Read word source: live address on entry from IDLE, registered address afterwards.
   always_comb begin
      rd_addr = (state == IDLE) ? bus.DADDR : addr_q;
      rd_word = 32'h0;
      if (rd_addr[31]) begin
         if (rd_addr[3:2] == 2'd1) rd_word = {31'h0, CON_VALID};
      end else begin
         rd_word = ram[rd_addr[MLEN+1:2]];
      end
   end

   // Byte offset and wrapped upper address bits do not take part in the read path.
   assign unused_addr = ^{rd_addr[1:0], rd_addr[30:MLEN+2]};

   // Stall: reads stall from the request cycle through WAIT; console writes stall while a byte is pending.
   always_comb begin
      bus.HLT = 1'b0;
      if (!RES) begin
         case (state)
            IDLE:    bus.HLT = req_rd | con_stall;
            WAIT:    bus.HLT = 1'b1;
            default: bus.HLT = 1'b0;
         endcase
      end
   end

   assign bus.DATAI = datai_q;
   assign state_dbg = state;

   // Read FSM: count wait states, capture the read word on entry to ACK.
   always_ff @(posedge CLK) begin
      if (RES) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'h0;
         datai_q <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_rd) begin
                  addr_q <= bus.DADDR;
                  cnt    <= WAITS_L;
                  if (WAITS_L == 4'd0) begin
                     state   <= ACK;
                     datai_q <= rd_word;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state   <= ACK;
                  datai_q <= rd_word;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM byte-lane writes; contents are deliberately not reset.
   always_ff @(posedge CLK) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (lanes[i]) ram[bus.DADDR[MLEN+1:2]][8*i +: 8] <= bus.DATAO[8*i +: 8];
         end
      end
   end

   // I/O page registers: console byte, finish/exit and the sticky error flag.
   always_ff @(posedge CLK) begin
      if (RES) begin
         CON_VALID <= 1'b0;
         CON_DATA  <= 8'h0;
         FINISH    <= 1'b0;
         EXIT      <= 32'h0;
         ERR       <= 1'b0;
      end else begin
         if (con_we) begin
            CON_VALID <= 1'b1;
            CON_DATA  <= bus.DATAO[7:0];
         end else if (CON_VALID && CON_READY) begin
            CON_VALID <= 1'b0;
         end
         if (fin_we) begin
            FINISH <= 1'b1;
            EXIT   <= bus.DATAO;
         end
         if (acc_err) ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_darkdmem.sv
// tb_darkdmem: self-checking bench for darkdmem. Two instances share the bus:
// dut_a with WAITS=2 for the main features, dut_b with WAITS=4 for the
// reset-during-wait scenario. A word-array reference model tracks RAM contents.
`timescale 1ns/1ps
module tb_darkdmem;
   localparam int MLEN = 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   darkdmem_if bus_a ();
   darkdmem_if bus_b ();

   logic        das, drd, dwr;
   logic [31:0] daddr, datao;
   logic [2:0]  dlen;
   logic        con_ready;
   logic        sel;

   assign bus_a.DAS = das;   assign bus_b.DAS = das;
   assign bus_a.DRD = drd;   assign bus_b.DRD = drd;
   assign bus_a.DWR = dwr;   assign bus_b.DWR = dwr;
   assign bus_a.DADDR = daddr; assign bus_b.DADDR = daddr;
   assign bus_a.DATAO = datao; assign bus_b.DATAO = datao;
   assign bus_a.DLEN = dlen; assign bus_b.DLEN = dlen;

   logic        con_valid_a, con_valid_b, finish_a, finish_b, err_a, err_b;
   logic [7:0]  con_data_a, con_data_b;
   logic [31:0] exit_a, exit_b;
   logic [1:0]  state_a, state_b;

   darkdmem #(.MLEN(MLEN), .WAITS(2)) dut_a (
      .CLK(clk), .RES(res), .bus(bus_a),
      .CON_VALID(con_valid_a), .CON_DATA(con_data_a), .CON_READY(con_ready),
      .FINISH(finish_a), .EXIT(exit_a), .ERR(err_a), .state_dbg(state_a));

   darkdmem #(.MLEN(MLEN), .WAITS(4)) dut_b (
      .CLK(clk), .RES(res), .bus(bus_b),
      .CON_VALID(con_valid_b), .CON_DATA(con_data_b), .CON_READY(con_ready),
      .FINISH(finish_b), .EXIT(exit_b), .ERR(err_b), .state_dbg(state_b));

   wire        cur_hlt   = sel ? bus_b.HLT   : bus_a.HLT;
   wire [31:0] cur_datai = sel ? bus_b.DATAI : bus_a.DATAI;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [31:0] mem_m [int];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];

   function automatic int model_idx(input logic [31:0] a);
      return int'((a >> 2) % (32'd1 << MLEN));
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] l);
      int idx;
      int nb;
      int first;
      logic [31:0] w;
      idx   = model_idx(a);
      nb    = (l == 3'b001) ? 1 : (l == 3'b010) ? 2 : 4;
      first = int'(a % 4);
      w     = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      for (int b = first; b < first + nb; b++) w[8*b +: 8] = d[8*b +: 8];
      mem_m[idx] = w;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int idx;
      idx = model_idx(a);
      return mem_m.exists(idx) ? mem_m[idx] : 32'h0;
   endfunction

   // console sink: record every byte handed over by dut_a
   always @(negedge clk) begin
      if (con_valid_a && con_ready) got_q.push_back(con_data_a);
   end

   // ---------------- driver tasks ----------------
   task automatic bus_idle();
      das = 1'b0; drd = 1'b0; dwr = 1'b0;
   endtask

   task automatic do_reset();
      res = 1'b1;
      bus_idle();
      @(posedge clk); @(posedge clk); #1;
      res = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l,
                           output int stall, output bit ok);
      das = 1'b1; dwr = 1'b1; drd = 1'b0; daddr = a; datao = d; dlen = l;
      stall = 0; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cur_hlt === 1'b0) begin ok = 1'b1; break; end
         stall++;
      end
      @(posedge clk); #1;
      bus_idle();
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] l, input bit wr_too,
                          output logic [31:0] data, output int stall, output bit ok);
      das = 1'b1; drd = 1'b1; dwr = wr_too; daddr = a; dlen = l; datao = $urandom;
      stall = 0; ok = 1'b0; data = 32'h0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cur_hlt === 1'b0) begin ok = 1'b1; data = cur_datai; break; end
         stall++;
      end
      @(posedge clk); #1;
      bus_idle();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      res = 1'b1;
      das = 1'b1; drd = 1'b1; dwr = 1'b0; daddr = 32'h10; dlen = 3'b100; datao = 32'h0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++; if (bus_a.HLT !== 1'b0) begin errors++; $display("FAIL reset_hlt_forced got %b exp 0", bus_a.HLT); end
      @(posedge clk); #1;
      bus_idle();
      res = 1'b0;
      @(negedge clk);
      checks++; if (bus_a.HLT !== 1'b0) begin errors++; $display("FAIL reset_hlt got %b exp 0", bus_a.HLT); end
      checks++; if (bus_a.DATAI !== 32'h0) begin errors++; $display("FAIL reset_datai got %h exp 0", bus_a.DATAI); end
      checks++; if (con_valid_a !== 1'b0) begin errors++; $display("FAIL reset_con_valid got %b exp 0", con_valid_a); end
      checks++; if (con_data_a !== 8'h0) begin errors++; $display("FAIL reset_con_data got %h exp 0", con_data_a); end
      checks++; if (finish_a !== 1'b0) begin errors++; $display("FAIL reset_finish got %b exp 0", finish_a); end
      checks++; if (exit_a !== 32'h0) begin errors++; $display("FAIL reset_exit got %h exp 0", exit_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_a); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int stall; bit ok; logic [31:0] d;
      do_write(32'h10, 32'hDEADBEEF, 3'b100, stall, ok);
      model_write(32'h10, 32'hDEADBEEF, 3'b100);
      checks++; if (!ok || stall != 0) begin errors++; $display("FAIL basic_write_stall got %0d ok %0d exp 0", stall, ok); end
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (!ok || stall != 3) begin errors++; $display("FAIL basic_read_stall got %0d ok %0d exp 3", stall, ok); end
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL basic_read_data got %h exp %h", d, model_read(32'h10)); end
      @(negedge clk);
      checks++; if (bus_a.DATAI !== 32'hDEADBEEF) begin errors++; $display("FAIL datai_hold got %h exp deadbeef", bus_a.DATAI); end
      checks++; if (bus_a.HLT !== 1'b0) begin errors++; $display("FAIL idle_hlt got %b exp 0", bus_a.HLT); end
      @(posedge clk); #1;
   endtask

   task automatic test_lanes();
      int stall; bit ok; logic [31:0] d;
      do_write(32'h10, 32'h11223344, 3'b100, stall, ok); model_write(32'h10, 32'h11223344, 3'b100);
      do_write(32'h13, 32'hAA000000, 3'b001, stall, ok); model_write(32'h13, 32'hAA000000, 3'b001);
      checks++; if (!ok || stall != 0) begin errors++; $display("FAIL byte_write_stall got %0d exp 0", stall); end
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL byte_lane got %h exp %h", d, model_read(32'h10)); end
      do_write(32'h10, 32'h00005566, 3'b010, stall, ok); model_write(32'h10, 32'h00005566, 3'b010);
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL half_lane got %h exp %h", d, model_read(32'h10)); end
   endtask

   task automatic test_back_to_back();
      int stall; bit ok; logic [31:0] d, a, w, up;
      logic [2:0] l;
      for (int n = 0; n < 24; n++) begin
         a = 32'($urandom_range(0, 63)) * 4;
         if (!mem_m.exists(model_idx(a))) begin
            w = $urandom;
            do_write(a, w, 3'b100, stall, ok); model_write(a, w, 3'b100);
         end
         case ($urandom_range(0, 2))
            0:       begin l = 3'b001; a = a + 32'($urandom_range(0, 3)); end
            1:       begin l = 3'b010; a = a + 32'($urandom_range(0, 1)) * 2; end
            default: l = 3'b100;
         endcase
         up = $urandom & 32'h7FFFC000;
         w  = $urandom;
         do_write(a | up, w, l, stall, ok); model_write(a, w, l);
         checks++; if (!ok || stall != 0) begin errors++; $display("FAIL rnd_write_stall n=%0d got %0d exp 0", n, stall); end
         up = $urandom & 32'h7FFFC000;
         do_read((a & ~32'h3) | up, 3'b100, 1'b0, d, stall, ok);
         checks++; if (!ok || stall != 3 || d !== model_read(a)) begin
            errors++; $display("FAIL rnd_read n=%0d addr %h got %h stall %0d exp %h stall 3", n, a, d, stall, model_read(a));
         end
      end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rnd_err got %b exp 0", err_a); end
   endtask

   task automatic test_misaligned();
      int stall; bit ok; logic [31:0] d;
      do_write(32'h12, 32'h0BADF00D, 3'b100, stall, ok);
      checks++; if (!ok || stall != 0) begin errors++; $display("FAIL misalign_stall got %0d exp 0", stall); end
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", err_a); end
      do_write(32'h11, 32'h0000FFFF, 3'b010, stall, ok);
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL misalign_ram got %h exp %h", d, model_read(32'h10)); end
      do_reset();
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err_a); end
      do_write(32'h10, 32'hFFFFFFFF, 3'b011, stall, ok);
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL bad_dlen_err got %b exp 1", err_a); end
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL bad_dlen_ram got %h exp %h", d, model_read(32'h10)); end
      do_reset();
      do_read(32'h10, 3'b100, 1'b1, d, stall, ok);
      checks++; if (!ok || stall != 3 || d !== model_read(32'h10)) begin
         errors++; $display("FAIL rd_wr_as_read got %h stall %0d exp %h stall 3", d, stall, model_read(32'h10));
      end
      checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL rd_wr_err got %b exp 1", err_a); end
      do_read(32'h10, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== model_read(32'h10)) begin errors++; $display("FAIL rd_wr_ram got %h exp %h", d, model_read(32'h10)); end
      do_reset();
   endtask

   task automatic test_console();
      int stall; bit ok; bit done; logic [31:0] d; logic [7:0] b;
      con_ready = 1'b0;
      do_write(32'h80000000, 32'h41, 3'b001, stall, ok); exp_q.push_back(8'h41);
      checks++; if (!ok || stall != 0) begin errors++; $display("FAIL con_first_stall got %0d exp 0", stall); end
      checks++; if (con_valid_a !== 1'b1 || con_data_a !== 8'h41) begin
         errors++; $display("FAIL con_first got v=%b d=%h exp v=1 d=41", con_valid_a, con_data_a);
      end
      fork
         begin do_write(32'h80000000, 32'h42, 3'b001, stall, ok); end
         begin repeat (4) @(posedge clk); #1; con_ready = 1'b1; end
      join
      exp_q.push_back(8'h42);
      // held for the 4 cycles without ready plus the drain cycle
      checks++; if (!ok || stall != 5) begin errors++; $display("FAIL con_stall got %0d ok %0d exp 5", stall, ok); end
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 10; n++) begin
               b = 8'($urandom);
               do_write(32'h80000000, {24'h0, b}, 3'b001, stall, ok);
               if (ok) exp_q.push_back(b);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin @(posedge clk); #1; con_ready = 1'($urandom_range(0, 1)); end
         end
      join
      con_ready = 1'b0;
      repeat (3) @(posedge clk); #1;
      con_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      con_ready = 1'b0;
      do_write(32'h80000000, 32'h43, 3'b001, stall, ok); exp_q.push_back(8'h43);
      do_read(32'h80000004, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL status_pending got %h exp 1", d); end
      do_read(32'h8000000C, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_read got %h exp 0", d); end
      con_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      do_read(32'h80000004, 3'b100, 1'b0, d, stall, ok);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL status_empty got %h exp 0", d); end
      checks++; if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL con_count got %0d exp %0d", got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL con_byte[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_finish();
      int stall; bit ok; logic [31:0] d, w;
      checks++; if (finish_a !== 1'b0) begin errors++; $display("FAIL finish_pre got %b exp 0", finish_a); end
      do_write(32'h80000008, 32'h2A, 3'b100, stall, ok);
      checks++; if (finish_a !== 1'b1 || exit_a !== 32'h2A) begin
         errors++; $display("FAIL finish_first got f=%b e=%h exp f=1 e=2a", finish_a, exit_a);
      end
      w = $urandom;
      do_write(32'h80000008, w, 3'b100, stall, ok);
      do_write(32'h20, 32'h5A5A5A5A, 3'b100, stall, ok); model_write(32'h20, 32'h5A5A5A5A, 3'b100);
      do_read(32'h20, 3'b100, 1'b0, d, stall, ok);
      checks++; if (finish_a !== 1'b1 || exit_a !== w) begin
         errors++; $display("FAIL finish_update got f=%b e=%h exp f=1 e=%h", finish_a, exit_a, w);
      end
      do_reset();
      checks++; if (finish_a !== 1'b0 || exit_a !== 32'h0) begin
         errors++; $display("FAIL finish_reset got f=%b e=%h exp f=0 e=0", finish_a, exit_a);
      end
   endtask

   task automatic test_reset_wait();
      int stall; bit ok; logic [31:0] d, w;
      sel = 1'b1;
      do_reset();
      w = $urandom;
      do_write(32'h40, w, 3'b100, stall, ok); model_write(32'h40, w, 3'b100);
      das = 1'b1; drd = 1'b1; dwr = 1'b0; daddr = 32'h40; dlen = 3'b100;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus_b.HLT !== 1'b1) begin errors++; $display("FAIL rw_in_wait got %b exp 1", bus_b.HLT); end
      @(posedge clk); #1;
      res = 1'b1;
      bus_idle();
      @(posedge clk); #1;
      res = 1'b0;
      @(negedge clk);
      checks++; if (bus_b.HLT !== 1'b0) begin errors++; $display("FAIL rw_hlt_after got %b exp 0", bus_b.HLT); end
      @(posedge clk); #1;
      do_read(32'h40, 3'b100, 1'b0, d, stall, ok);
      checks++; if (!ok || stall != 5) begin errors++; $display("FAIL rw_fresh_stall got %0d exp 5", stall); end
      checks++; if (d !== model_read(32'h40)) begin errors++; $display("FAIL rw_fresh_data got %h exp %h", d, model_read(32'h40)); end
      sel = 1'b0;
      do_reset();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus_idle();
      daddr = 32'h0; datao = 32'h0; dlen = 3'b100;
      con_ready = 1'b0;
      sel = 1'b0;
      test_reset();
      test_basic();
      test_lanes();
      test_back_to_back();
      test_misaligned();
      test_console();
      test_finish();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
